// File: rtl/weight_fifo_arr_ctrl.sv
// Weight-load responder: drains one weight tile from the FIFO into the systolic array,
// zero-pads unused rows, commits the tile into the PEs and answers the master with done.
module weight_fifo_arr_ctrl #(
    parameter int WIDTH_HEIGHT = 16,
    parameter int CNT_W        = $clog2(WIDTH_HEIGHT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] num_row_weight_mat,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic             arr_shift,
    output logic             arr_zero_fill,
    output logic             arr_load,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT,
        DONE
    } state_t;

    localparam logic [CNT_W:0] TILE_ROWS = (CNT_W+1)'(WIDTH_HEIGHT);
    localparam logic [CNT_W:0] CNT_ONE   = (CNT_W+1)'(1);

    state_t         state_q, state_d;
    logic [CNT_W:0] rows_q, rows_d;
    logic [CNT_W:0] i_q, i_d;
    logic           tok_valid_q, tok_valid_d;
    logic           tok_zero_q, tok_zero_d;
    logic           load_phase_q, load_phase_d;
    logic           data_row;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rows_q       <= '0;
            i_q          <= '0;
            tok_valid_q  <= 1'b0;
            tok_zero_q   <= 1'b0;
            load_phase_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rows_q       <= rows_d;
            i_q          <= i_d;
            tok_valid_q  <= tok_valid_d;
            tok_zero_q   <= tok_zero_d;
            load_phase_q <= load_phase_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rows_d       = rows_q;
        i_d          = i_q;
        tok_valid_d  = 1'b0;
        tok_zero_d   = 1'b0;
        load_phase_d = 1'b0;
        fifo_rd_en   = 1'b0;
        arr_load     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        data_row     = (i_q < rows_q);

        case (state_q)
            IDLE: begin
                if (en) begin
                    // A row count of zero means a full tile.
                    rows_d  = (num_row_weight_mat == '0) ? TILE_ROWS
                                                         : {1'b0, num_row_weight_mat};
                    i_d     = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                busy = 1'b1;
                if (data_row) begin
                    if (!fifo_empty) begin
                        fifo_rd_en  = 1'b1;
                        tok_valid_d = 1'b1;
                        i_d         = i_q + CNT_ONE;
                    end
                end else begin
                    tok_valid_d = 1'b1;
                    tok_zero_d  = 1'b1;
                    i_d         = i_q + CNT_ONE;
                end
                if (i_d == TILE_ROWS) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                // First cycle lets the last shift land; second cycle latches the PEs.
                busy = 1'b1;
                if (load_phase_q) begin
                    arr_load = 1'b1;
                    state_d  = DONE;
                end else begin
                    load_phase_d = 1'b1;
                end
            end
            DONE: begin
                done = 1'b1;
                if (!en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign arr_shift     = tok_valid_q;
    assign arr_zero_fill = tok_valid_q & tok_zero_q;

endmodule
